// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle control unit: states, opcodes, ALU codes, flag bits,
// condition codes and the opcode-to-ALU mapping.
package ctrl_pkg;

  localparam int unsigned AluContBits = 6;

  typedef enum logic [3:0] {
    StFetch,
    StIrLatch,
    StRegRd,
    StAlu,
    StLdAddr,
    StLdWb,
    StStore,
    StJal,
    StJcond,
    StBcond,
    StHalt
  } state_e;

  // Primary opcodes (instr[15:12])
  localparam logic [3:0] OpRType = 4'b0000;
  localparam logic [3:0] OpAndi  = 4'b0001;
  localparam logic [3:0] OpOri   = 4'b0010;
  localparam logic [3:0] OpXori  = 4'b0011;
  localparam logic [3:0] OpMem   = 4'b0100;
  localparam logic [3:0] OpAddi  = 4'b0101;
  localparam logic [3:0] OpSubi  = 4'b1001;
  localparam logic [3:0] OpCmpi  = 4'b1011;
  localparam logic [3:0] OpBcond = 4'b1100;
  localparam logic [3:0] OpMovi  = 4'b1101;
  localparam logic [3:0] OpLui   = 4'b1111;

  // Extended opcodes (instr[7:4])
  localparam logic [3:0] ExtNop   = 4'b0000;
  localparam logic [3:0] ExtAnd   = 4'b0001;
  localparam logic [3:0] ExtOr    = 4'b0010;
  localparam logic [3:0] ExtXor   = 4'b0011;
  localparam logic [3:0] ExtAdd   = 4'b0101;
  localparam logic [3:0] ExtSub   = 4'b1001;
  localparam logic [3:0] ExtCmp   = 4'b1011;
  localparam logic [3:0] ExtMov   = 4'b1101;
  localparam logic [3:0] ExtLoad  = 4'b0000;
  localparam logic [3:0] ExtStor  = 4'b0100;
  localparam logic [3:0] ExtJal   = 4'b1000;
  localparam logic [3:0] ExtJcond = 4'b1100;

  localparam logic [AluContBits-1:0] ALU_ADD = 6'd0;
  localparam logic [AluContBits-1:0] ALU_SUB = 6'd1;
  localparam logic [AluContBits-1:0] ALU_AND = 6'd2;
  localparam logic [AluContBits-1:0] ALU_OR  = 6'd3;
  localparam logic [AluContBits-1:0] ALU_XOR = 6'd4;
  localparam logic [AluContBits-1:0] ALU_MOV = 6'd5;
  localparam logic [AluContBits-1:0] ALU_LUI = 6'd6;
  localparam logic [AluContBits-1:0] ALU_CMP = 6'd7;

  localparam int unsigned FlagC = 0;
  localparam int unsigned FlagL = 2;
  localparam int unsigned FlagF = 5;
  localparam int unsigned FlagZ = 6;
  localparam int unsigned FlagN = 7;

  localparam logic [3:0] CondEq  = 4'b0000;
  localparam logic [3:0] CondNe  = 4'b0001;
  localparam logic [3:0] CondCs  = 4'b0010;
  localparam logic [3:0] CondCc  = 4'b0011;
  localparam logic [3:0] CondLo  = 4'b0100;
  localparam logic [3:0] CondNlo = 4'b0101;
  localparam logic [3:0] CondMi  = 4'b0110;
  localparam logic [3:0] CondPl  = 4'b0111;
  localparam logic [3:0] CondFs  = 4'b1000;
  localparam logic [3:0] CondFc  = 4'b1001;
  localparam logic [3:0] CondHi  = 4'b1010;
  localparam logic [3:0] CondLs  = 4'b1011;
  localparam logic [3:0] CondGt  = 4'b1100;
  localparam logic [3:0] CondLe  = 4'b1101;
  localparam logic [3:0] CondUc  = 4'b1110;
  localparam logic [3:0] CondNv  = 4'b1111;

  localparam logic [1:0] PcSrcAlu   = 2'd0;
  localparam logic [1:0] PcSrcRegB  = 2'd1;
  localparam logic [1:0] PcSrcPcInc = 2'd2;

  localparam logic [1:0] RwSrcAlu   = 2'd0;
  localparam logic [1:0] RwSrcMem   = 2'd1;
  localparam logic [1:0] RwSrcPcInc = 2'd2;

  // Register and immediate forms share the same 4-bit code for each ALU operation.
  function automatic logic [AluContBits-1:0] alu_code(input logic [3:0] code);
    unique case (code)
      ExtAdd:  return ALU_ADD;
      ExtSub:  return ALU_SUB;
      ExtCmp:  return ALU_CMP;
      ExtAnd:  return ALU_AND;
      ExtOr:   return ALU_OR;
      ExtXor:  return ALU_XOR;
      ExtMov:  return ALU_MOV;
      OpLui:   return ALU_LUI;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/cond_eval.sv
// Branch/jump condition evaluator: combinational map of a 4-bit condition code onto PSR flags.
module cond_eval
  import ctrl_pkg::*;
#(
  parameter int unsigned Width = 16
) (
  input  logic [3:0]       cond_i,
  input  logic [Width-1:0] psr_flags_i,
  output logic             taken_o
);

  logic c, l, f, z, n;
  logic unused_flags;

  assign c = psr_flags_i[FlagC];
  assign l = psr_flags_i[FlagL];
  assign f = psr_flags_i[FlagF];
  assign z = psr_flags_i[FlagZ];
  assign n = psr_flags_i[FlagN];
  assign unused_flags = ^{psr_flags_i[Width-1:8], psr_flags_i[4:3], psr_flags_i[1]};

  always_comb begin
    taken_o = 1'b0;
    unique case (cond_i)
      CondEq:  taken_o = z;
      CondNe:  taken_o = !z;
      CondCs:  taken_o = c;
      CondCc:  taken_o = !c;
      CondLo:  taken_o = l;
      CondNlo: taken_o = !l;
      CondMi:  taken_o = n;
      CondPl:  taken_o = !n;
      CondFs:  taken_o = f;
      CondFc:  taken_o = !f;
      CondHi:  taken_o = !l && !z;
      CondLs:  taken_o = l || z;
      CondGt:  taken_o = !n && !z;
      CondLe:  taken_o = n || z;
      CondUc:  taken_o = 1'b1;
      CondNv:  taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/control_fsm.sv
// Multicycle control FSM for the 16-bit CPU datapath.
// Optional retired-instruction counter enabled by defining CTRL_RETIRE_CNT_EN.
module control_fsm
  import ctrl_pkg::*;
#(
  parameter int unsigned ALU_CONT_BITS    = 6,
  parameter int unsigned OP_CODE_BITS     = 4,
  parameter int unsigned EXT_OP_CODE_BITS = 4,
  parameter int unsigned WIDTH            = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [OP_CODE_BITS-1:0]     op_code,
  input  logic [EXT_OP_CODE_BITS-1:0] ext_op_code,
  input  logic [3:0]                  cond,
  input  logic [WIDTH-1:0]            psr_flags,
  output logic                        reg_write,
  output logic                        alu_A_src,
  output logic                        alu_B_src,
  output logic                        pc_en,
  output logic                        loading,
  output logic                        storing,
  output logic                        instruction_en,
  output logic                        mem_write,
  output logic [1:0]                  pc_src,
  output logic [1:0]                  reg_write_src,
  output logic [ALU_CONT_BITS-1:0]    alu_cont,
  output logic                        halted,
  output logic [WIDTH-1:0]            retired_count
);

  state_e state_q, state_d;
  logic   taken;
  logic   is_rtype_alu, is_imm_alu, no_writeback;

  cond_eval #(
    .Width (WIDTH)
  ) u_cond_eval (
    .cond_i      (cond),
    .psr_flags_i (psr_flags),
    .taken_o     (taken)
  );

  always_comb begin
    is_rtype_alu = 1'b0;
    if (op_code == OpRType) begin
      unique case (ext_op_code)
        ExtNop, ExtAdd, ExtSub, ExtCmp, ExtAnd, ExtOr, ExtXor, ExtMov: is_rtype_alu = 1'b1;
        default: is_rtype_alu = 1'b0;
      endcase
    end
  end

  always_comb begin
    is_imm_alu = 1'b0;
    unique case (op_code)
      OpAddi, OpSubi, OpCmpi, OpAndi, OpOri, OpXori, OpMovi, OpLui: is_imm_alu = 1'b1;
      default: is_imm_alu = 1'b0;
    endcase
  end

  assign no_writeback = (op_code == OpCmpi) ||
                        ((op_code == OpRType) && (ext_op_code == ExtCmp || ext_op_code == ExtNop));

  always_comb begin
    state_d        = state_q;
    reg_write      = 1'b0;
    alu_A_src      = 1'b0;
    alu_B_src      = 1'b0;
    pc_en          = 1'b0;
    loading        = 1'b0;
    storing        = 1'b0;
    instruction_en = 1'b0;
    mem_write      = 1'b0;
    halted         = 1'b0;
    pc_src         = PcSrcPcInc;
    reg_write_src  = RwSrcAlu;
    alu_cont       = ALU_CONT_BITS'(ALU_ADD);

    unique case (state_q)
      StFetch: state_d = StIrLatch;
      StIrLatch: begin
        instruction_en = 1'b1;
        state_d        = StRegRd;
      end
      StRegRd: begin
        if (is_rtype_alu || is_imm_alu) begin
          state_d = StAlu;
        end else if (op_code == OpMem) begin
          unique case (ext_op_code)
            ExtLoad:  state_d = StLdAddr;
            ExtStor:  state_d = StStore;
            ExtJal:   state_d = StJal;
            ExtJcond: state_d = StJcond;
            default:  state_d = StHalt;
          endcase
        end else if (op_code == OpBcond) begin
          state_d = StBcond;
        end else begin
          state_d = StHalt;
        end
      end
      StAlu: begin
        alu_A_src = 1'b1;
        alu_B_src = (op_code != OpRType);
        alu_cont  = ALU_CONT_BITS'(alu_code((op_code == OpRType) ? ext_op_code : op_code));
        reg_write = !no_writeback;
        pc_en     = 1'b1;
        state_d   = StFetch;
      end
      StLdAddr: begin
        loading = 1'b1;
        state_d = StLdWb;
      end
      StLdWb: begin
        loading       = 1'b1;
        reg_write     = 1'b1;
        reg_write_src = RwSrcMem;
        pc_en         = 1'b1;
        state_d       = StFetch;
      end
      StStore: begin
        storing   = 1'b1;
        mem_write = 1'b1;
        pc_en     = 1'b1;
        state_d   = StFetch;
      end
      StJal: begin
        reg_write     = 1'b1;
        reg_write_src = RwSrcPcInc;
        pc_en         = 1'b1;
        pc_src        = PcSrcRegB;
        state_d       = StFetch;
      end
      StJcond: begin
        pc_en   = 1'b1;
        pc_src  = taken ? PcSrcRegB : PcSrcPcInc;
        state_d = StFetch;
      end
      StBcond: begin
        // Target is pc + imm; pc still holds the branch's own address here.
        alu_B_src = 1'b1;
        pc_en     = 1'b1;
        pc_src    = taken ? PcSrcAlu : PcSrcPcInc;
        state_d   = StFetch;
      end
      StHalt: halted = 1'b1;
      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef CTRL_RETIRE_CNT_EN
  logic [WIDTH-1:0] retired_q, retired_d;

  assign retired_d = pc_en ? retired_q + WIDTH'(1) : retired_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      retired_q <= '0;
    end else begin
      retired_q <= retired_d;
    end
  end

  assign retired_count = retired_q;
`else
  assign retired_count = '0;
`endif

endmodule

// File: tb/tb_control_fsm.sv
// Directed self-checking bench for control_fsm; every output compared cycle by cycle.
module tb_control_fsm;
  import ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  op_code, ext_op_code, cond;
  logic [15:0] psr_flags;
  logic        reg_write, alu_A_src, alu_B_src, pc_en, loading, storing;
  logic        instruction_en, mem_write, halted;
  logic [1:0]  pc_src, reg_write_src;
  logic [5:0]  alu_cont;
  logic [15:0] retired_count;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  logic [15:0] exp_cnt = 16'd0;

  control_fsm dut (
    .clk            (clk),
    .reset          (reset),
    .op_code        (op_code),
    .ext_op_code    (ext_op_code),
    .cond           (cond),
    .psr_flags      (psr_flags),
    .reg_write      (reg_write),
    .alu_A_src      (alu_A_src),
    .alu_B_src      (alu_B_src),
    .pc_en          (pc_en),
    .loading        (loading),
    .storing        (storing),
    .instruction_en (instruction_en),
    .mem_write      (mem_write),
    .pc_src         (pc_src),
    .reg_write_src  (reg_write_src),
    .alu_cont       (alu_cont),
    .halted         (halted),
    .retired_count  (retired_count)
  );

  always #5 clk = ~clk;

  // {rw, aA, aB, pc_en, ld, st, ie, mw, halted, pc_src, rw_src, alu_cont}
  function automatic logic [18:0] v(input logic rw, input logic aa, input logic ab,
                                    input logic pe, input logic ld, input logic st,
                                    input logic ie, input logic mw, input logic h,
                                    input logic [1:0] ps, input logic [1:0] rs,
                                    input logic [5:0] alu);
    return {rw, aa, ab, pe, ld, st, ie, mw, h, ps, rs, alu};
  endfunction

  logic [18:0] obs, dflt;
  assign obs = {reg_write, alu_A_src, alu_B_src, pc_en, loading, storing, instruction_en,
                mem_write, halted, pc_src, reg_write_src, alu_cont};
  assign dflt = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd2, 2'd0, ALU_ADD);

  task automatic chk(input string tag, input logic [18:0] exp);
    n_cmp++;
    assert ({obs, retired_count} === {exp, exp_cnt}) else begin
      n_bad++;
      $error("FAIL %s: outputs=%05h count=%04h, expected outputs=%05h count=%04h",
             tag, obs, retired_count, exp, exp_cnt);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [3:0] op, input logic [3:0] ext, input logic [3:0] cnd,
                        input logic [15:0] flags);
    op_code     = op;
    ext_op_code = ext;
    cond        = cnd;
    psr_flags   = flags;
  endtask

  // FETCH, IR latch and register read are common to every instruction.
  task automatic front(input string tag);
    chk({tag, "_fetch"}, dflt);
    step();
    chk({tag, "_ir"}, v(0, 0, 0, 0, 0, 0, 1, 0, 0, 2'd2, 2'd0, ALU_ADD));
    step();
    chk({tag, "_rd"}, dflt);
    step();
  endtask

  // Checks a cycle, then advances; the counter model steps on pc_en cycles.
  task automatic exec(input string tag, input logic [18:0] exp);
    chk(tag, exp);
`ifdef CTRL_RETIRE_CNT_EN
    if (exp[15]) exp_cnt = exp_cnt + 16'd1;
`endif
    step();
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b0;
    #1;
    exp_cnt = 16'd0;
    chk("halt_rst", dflt);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    set_in(4'h0, 4'h0, 4'h0, 16'h0000);
    #1;
    chk("rst_async", dflt);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_held", dflt);
    @(negedge clk);
    reset = 1'b1;

    set_in(OpRType, 4'b0101, 4'h1, 16'h0000);
    front("add");
    exec("add_alu", v(1, 1, 0, 1, 0, 0, 0, 0, 0, 2'd2, 2'd0, ALU_ADD));

    set_in(4'b1011, 4'h3, 4'h1, 16'h0000);
    front("cmpi");
    exec("cmpi_alu", v(0, 1, 1, 1, 0, 0, 0, 0, 0, 2'd2, 2'd0, ALU_CMP));

    set_in(OpRType, 4'b1001, 4'h2, 16'h0000);
    front("sub");
    exec("sub_alu", v(1, 1, 0, 1, 0, 0, 0, 0, 0, 2'd2, 2'd0, ALU_SUB));

    set_in(4'b1111, 4'h7, 4'h2, 16'h0000);
    front("lui");
    exec("lui_alu", v(1, 1, 1, 1, 0, 0, 0, 0, 0, 2'd2, 2'd0, ALU_LUI));

    set_in(4'b0011, 4'h7, 4'h2, 16'h0000);
    front("xori");
    exec("xori_alu", v(1, 1, 1, 1, 0, 0, 0, 0, 0, 2'd2, 2'd0, ALU_XOR));

    set_in(OpRType, 4'b1101, 4'h2, 16'h0000);
    front("mov");
    exec("mov_alu", v(1, 1, 0, 1, 0, 0, 0, 0, 0, 2'd2, 2'd0, ALU_MOV));

    set_in(OpRType, 4'b0000, 4'h0, 16'h0000);
    front("nop");
    exec("nop_alu", v(0, 1, 0, 1, 0, 0, 0, 0, 0, 2'd2, 2'd0, ALU_ADD));

    set_in(4'b0100, 4'b0000, 4'h3, 16'h0000);
    front("load");
    exec("load_addr", v(0, 0, 0, 0, 1, 0, 0, 0, 0, 2'd2, 2'd0, ALU_ADD));
    exec("load_wb", v(1, 0, 0, 1, 1, 0, 0, 0, 0, 2'd2, 2'd1, ALU_ADD));

    set_in(4'b0100, 4'b0100, 4'h3, 16'h0000);
    front("stor");
    exec("stor_mem", v(0, 0, 0, 1, 0, 1, 0, 1, 0, 2'd2, 2'd0, ALU_ADD));
    chk("stor_after", dflt);

    set_in(4'b1100, 4'b0000, 4'b0000, 16'h0040);
    front("beq_t");
    exec("beq_taken", v(0, 0, 1, 1, 0, 0, 0, 0, 0, 2'd0, 2'd0, ALU_ADD));
    set_in(4'b1100, 4'b0000, 4'b0000, 16'h0000);
    front("beq_n");
    exec("beq_not", v(0, 0, 1, 1, 0, 0, 0, 0, 0, 2'd2, 2'd0, ALU_ADD));
    set_in(4'b1100, 4'b0000, 4'b1111, 16'h0040);
    front("bnv");
    exec("b_never", v(0, 0, 1, 1, 0, 0, 0, 0, 0, 2'd2, 2'd0, ALU_ADD));
    set_in(4'b1100, 4'b0000, 4'b1010, 16'h0004);
    front("bhi_n");
    exec("bhi_not", v(0, 0, 1, 1, 0, 0, 0, 0, 0, 2'd2, 2'd0, ALU_ADD));
    set_in(4'b1100, 4'b0000, 4'b1010, 16'h0000);
    front("bhi_t");
    exec("bhi_taken", v(0, 0, 1, 1, 0, 0, 0, 0, 0, 2'd0, 2'd0, ALU_ADD));

    set_in(4'b0100, 4'b1100, 4'b0010, 16'h0001);
    front("jcs_t");
    exec("jcs_taken", v(0, 0, 0, 1, 0, 0, 0, 0, 0, 2'd1, 2'd0, ALU_ADD));
    set_in(4'b0100, 4'b1100, 4'b0011, 16'h0001);
    front("jcc_n");
    exec("jcc_not", v(0, 0, 0, 1, 0, 0, 0, 0, 0, 2'd2, 2'd0, ALU_ADD));
    set_in(4'b0100, 4'b1100, 4'b1101, 16'h0080);
    front("jle_t");
    exec("jle_taken", v(0, 0, 0, 1, 0, 0, 0, 0, 0, 2'd1, 2'd0, ALU_ADD));

    set_in(4'b0100, 4'b1000, 4'h5, 16'h0000);
    front("jal");
    exec("jal_link", v(1, 0, 0, 1, 0, 0, 0, 0, 0, 2'd1, 2'd2, ALU_ADD));

    set_in(4'b0111, 4'b0000, 4'h0, 16'h0000);
    front("halt");
    for (int i = 0; i < 20; i++) exec("halt_hold", v(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd2, 2'd0, ALU_ADD));
    pulse_reset();

    set_in(OpRType, 4'b0111, 4'h0, 16'h0000);
    front("bad_ext");
    exec("bad_ext_halt", v(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd2, 2'd0, ALU_ADD));
    pulse_reset();

    set_in(OpRType, 4'b0101, 4'h1, 16'h0000);
    front("add2");
    exec("add2_alu", v(1, 1, 0, 1, 0, 0, 0, 0, 0, 2'd2, 2'd0, ALU_ADD));

    set_in(4'b0100, 4'b0000, 4'h3, 16'h0000);
    front("ldrst");
    chk("ldrst_addr", v(0, 0, 0, 0, 1, 0, 0, 0, 0, 2'd2, 2'd0, ALU_ADD));
    reset = 1'b0;
    #1;
    exp_cnt = 16'd0;
    chk("ldrst_abort", dflt);
    @(negedge clk);
    reset = 1'b1;
    chk("ldrst_fetch", dflt);
    step();
    chk("ldrst_ir", v(0, 0, 0, 0, 0, 0, 1, 0, 0, 2'd2, 2'd0, ALU_ADD));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
